// File: rtl/i2c_codec_target.sv
// Write-only I2C target modelling the WM8731 control port: oversamples SCL/SDA on i_clk,
// ACKs the {DEV_ADDR,0} + 2-byte write and reports each decoded register write.
module i2c_codec_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         SYNC_STAGES = 2      // 2 or 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oen,
    output logic       o_wr_valid,
    output logic [6:0] o_wr_reg,
    output logic [8:0] o_wr_data,
    output logic       o_busy,
    output logic       o_err,
    output logic [7:0] o_wr_count
);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ACK_A, S_B0, S_ACK_0, S_B1, S_ACK_1, S_DONE, S_IGNORE
    } state_t;

    localparam logic [7:0] WR_BYTE = {DEV_ADDR, 1'b0};

    logic [SYNC_STAGES-1:0] scl_sync_reg;
    logic [SYNC_STAGES-1:0] sda_sync_reg;
    logic                   scl_prev_reg;
    logic                   sda_prev_reg;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   sda_rise;
    logic                   sda_fall;
    logic                   start_cond;
    logic                   stop_cond;

    state_t                 state_reg;
    state_t                 state_next;

    logic [2:0]             bit_cnt_reg;
    logic                   byte_full_reg;
    logic [7:0]             shift_reg;
    logic [7:0]             b0_reg;
    logic                   shifting;
    logic                   byte_end;
    logic                   mid_write;

    logic                   sda_oen_reg;
    logic                   sda_oen_next;
    logic                   wr_valid_reg;
    logic                   wr_valid_next;
    logic                   busy_reg;
    logic                   busy_next;
    logic                   err_reg;
    logic                   err_next;
    logic [6:0]             wr_reg_reg;
    logic [8:0]             wr_data_reg;
    logic [7:0]             wr_count_reg;

    // Synchronisers reset to the idle bus level so leaving reset never fakes a condition.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], i_scl};
            sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], i_sda};
            scl_prev_reg <= scl_s;
            sda_prev_reg <= sda_s;
        end
    end

    assign scl_s      = scl_sync_reg[SYNC_STAGES-1];
    assign sda_s      = sda_sync_reg[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_prev_reg;
    assign scl_fall   = ~scl_s & scl_prev_reg;
    assign sda_rise   = sda_s & ~sda_prev_reg;
    assign sda_fall   = ~sda_s & sda_prev_reg;
    assign start_cond = sda_fall & scl_s & scl_prev_reg;
    assign stop_cond  = sda_rise & scl_s & scl_prev_reg;

    assign shifting  = (state_reg == S_ADDR) || (state_reg == S_B0) || (state_reg == S_B1);
    assign byte_end  = shifting && byte_full_reg && scl_fall && !start_cond && !stop_cond;
    assign mid_write = (state_reg != S_IDLE) && (state_reg != S_DONE) && (state_reg != S_IGNORE);

    // Bit sampler: 8 rises fill the byte, the following fall completes it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bit_cnt_reg   <= 3'd0;
            byte_full_reg <= 1'b0;
            shift_reg     <= 8'd0;
            b0_reg        <= 8'd0;
        end else if (start_cond || stop_cond) begin
            bit_cnt_reg   <= 3'd0;
            byte_full_reg <= 1'b0;
        end else if (shifting) begin
            if (scl_rise && !byte_full_reg) begin
                shift_reg   <= {shift_reg[6:0], sda_s};
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                if (bit_cnt_reg == 3'd7) begin
                    byte_full_reg <= 1'b1;
                end
            end else if (byte_end) begin
                byte_full_reg <= 1'b0;
                if (state_reg == S_B0) begin
                    b0_reg <= shift_reg;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (start_cond) begin
            state_next = S_ADDR;
        end else if (stop_cond) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_ADDR:  if (byte_end) state_next = (shift_reg == WR_BYTE) ? S_ACK_A : S_IGNORE;
                S_ACK_A: if (scl_fall) state_next = S_B0;
                S_B0:    if (byte_end) state_next = S_ACK_0;
                S_ACK_0: if (scl_fall) state_next = S_B1;
                S_B1:    if (byte_end) state_next = S_ACK_1;
                S_ACK_1: if (scl_fall) state_next = S_DONE;
                default: state_next = state_reg;
            endcase
        end
    end

    // Outputs are computed from the next state and registered, so SDA drive is glitch-free.
    always_comb begin
        sda_oen_next  = (state_next == S_ACK_A) || (state_next == S_ACK_0) || (state_next == S_ACK_1);
        busy_next     = (state_next != S_IDLE);
        err_next      = (start_cond || stop_cond) && mid_write;
        wr_valid_next = (state_reg == S_B1) && byte_end;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sda_oen_reg  <= 1'b0;
            wr_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
            err_reg      <= 1'b0;
            wr_reg_reg   <= 7'd0;
            wr_data_reg  <= 9'd0;
            wr_count_reg <= 8'd0;
        end else begin
            sda_oen_reg  <= sda_oen_next;
            wr_valid_reg <= wr_valid_next;
            busy_reg     <= busy_next;
            err_reg      <= err_next;
            if (wr_valid_next) begin
                wr_reg_reg   <= b0_reg[7:1];
                wr_data_reg  <= {b0_reg[0], shift_reg};
                wr_count_reg <= wr_count_reg + 8'd1;
            end
        end
    end

    assign o_sda_oen  = sda_oen_reg;
    assign o_wr_valid = wr_valid_reg;
    assign o_wr_reg   = wr_reg_reg;
    assign o_wr_data  = wr_data_reg;
    assign o_busy     = busy_reg;
    assign o_err      = err_reg;
    assign o_wr_count = wr_count_reg;

endmodule

// File: tb/tb_i2c_codec_target.sv
// Bench for i2c_codec_target: bit-banged I2C initiator, write scoreboard and per-scenario checks.
`timescale 1ns/1ps
module tb_i2c_codec_target;
    localparam int SYNC_STAGES = 2;
    localparam int H           = 12;   // i_clk cycles per SCL half period

    localparam logic [15:0] INIT_SEQ [11] = '{
        {7'h0F, 9'h000}, {7'h00, 9'h017}, {7'h01, 9'h017}, {7'h02, 9'h079},
        {7'h03, 9'h079}, {7'h04, 9'h012}, {7'h05, 9'h000}, {7'h06, 9'h000},
        {7'h07, 9'h042}, {7'h08, 9'h000}, {7'h09, 9'h001}
    };

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_drv = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_bus;
    logic       sda_oen;
    logic       wr_valid;
    logic [6:0] wr_reg;
    logic [8:0] wr_data;
    logic       busy;
    logic       err;
    logic [7:0] wr_count;

    assign sda_bus = sda_drv & ~sda_oen;

    always #5 clk = ~clk;

    i2c_codec_target #(.DEV_ADDR(7'h1A), .SYNC_STAGES(SYNC_STAGES)) dut (
        .i_clk(clk), .i_rst(rst), .i_scl(scl_drv), .i_sda(sda_bus),
        .o_sda_oen(sda_oen), .o_wr_valid(wr_valid), .o_wr_reg(wr_reg), .o_wr_data(wr_data),
        .o_busy(busy), .o_err(err), .o_wr_count(wr_count)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          last_fall_cyc = 0;
    int          last_valid_cyc = 0;
    int          valid_cnt = 0;
    int          err_cnt = 0;
    bit          oen_seen = 1'b0;
    logic [15:0] exp_q [$];
    logic [15:0] exp_item;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every reported write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst) begin
            if (sda_oen) oen_seen = 1'b1;
            if (err) err_cnt++;
            if (wr_valid) begin
                valid_cnt++;
                last_valid_cyc = cyc;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL wr_unexpected: got reg=%h data=%h, required no write", wr_reg, wr_data);
                end else begin
                    exp_item = exp_q.pop_front();
                    if ({wr_reg, wr_data} !== exp_item) begin
                        miscompares++;
                        $display("FAIL wr_report: got reg=%h data=%h, required reg=%h data=%h",
                                 wr_reg, wr_data, exp_item[15:9], exp_item[8:0]);
                    end else begin
                        $display("write reg=%h data=%h ok", wr_reg, wr_data);
                    end
                end
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Works from idle and as a repeated START from the SCL-low phase.
    task automatic i2c_start();
        sda_drv = 1'b1; wait_clks(H);
        scl_drv = 1'b1; wait_clks(H);
        sda_drv = 1'b0; wait_clks(H);
        scl_drv = 1'b0; wait_clks(H);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wait_clks(H);
        scl_drv = 1'b1; wait_clks(H);
        sda_drv = 1'b1; wait_clks(H);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit exp_ack, input bit rst_in_ack);
        for (int i = 7; i >= 0; i--) begin
            sda_drv = b[i]; wait_clks(H);
            scl_drv = 1'b1; wait_clks(H);
            scl_drv = 1'b0; last_fall_cyc = cyc;
            wait_clks(2);
        end
        sda_drv = 1'b1;
        wait_clks(H);
        vectors++;
        if (sda_bus !== ~exp_ack) begin
            miscompares++;
            $display("FAIL ack_slot byte=%h: sda=%b, required %b", b, sda_bus, ~exp_ack);
        end else begin
            $display("byte %h ack_slot sda=%b ok", b, sda_bus);
        end
        if (rst_in_ack) begin
            #3 rst = 1'b1;
            #1;
            vectors++;
            if (sda_oen !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_async_oen: got %b, required 0", sda_oen);
            end
            vectors++;
            if ({sda_oen, wr_valid, wr_reg, wr_data, busy, err, wr_count} !== 27'd0) begin
                miscompares++;
                $display("FAIL rst_outputs: got %h, required 0",
                         {sda_oen, wr_valid, wr_reg, wr_data, busy, err, wr_count});
            end
            wait_clks(3);
            rst = 1'b0;
        end
        scl_drv = 1'b1; wait_clks(H);
        scl_drv = 1'b0; wait_clks(2);
    endtask

    task automatic do_write(input logic [6:0] r, input logic [8:0] d);
        exp_q.push_back({r, d});
        i2c_start();
        send_byte(8'h34, 1'b1, 1'b0);
        send_byte({r, d[8]}, 1'b1, 1'b0);
        send_byte(d[7:0], 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        wait_clks(3);
        vectors++;
        if ({sda_oen, wr_valid, wr_reg, wr_data, busy, err, wr_count} !== 27'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {sda_oen, wr_valid, wr_reg, wr_data, busy, err, wr_count});
        end
        rst = 1'b0;
        wait_clks(4);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_single_write();
        int v0 = valid_cnt;
        int e0 = err_cnt;
        do_write(7'h04, 9'h015);
        vectors++;
        if (last_valid_cyc - last_fall_cyc != SYNC_STAGES + 1) begin
            miscompares++;
            $display("FAIL wr_latency: got %0d, required %0d", last_valid_cyc - last_fall_cyc, SYNC_STAGES + 1);
        end
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_busy: got %b, required 1", busy);
        end
        i2c_stop();
        wait_clks(4);
        vectors++;
        if (valid_cnt - v0 != 1 || err_cnt != e0 || wr_count !== 8'd1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_write: valid=%0d err=%0d count=%0d busy=%b, required 1 0 1 0",
                     valid_cnt - v0, err_cnt - e0, wr_count, busy);
        end
    endtask

    task automatic test_addr_mismatch();
        int v0 = valid_cnt;
        int e0 = err_cnt;
        oen_seen = 1'b0;
        i2c_start();
        send_byte(8'h36, 1'b0, 1'b0);
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mismatch_busy: got %b, required 1", busy);
        end
        i2c_stop();
        wait_clks(4);
        vectors++;
        if (oen_seen || valid_cnt != v0 || err_cnt != e0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL addr_mismatch: oen_seen=%b valid=%0d err=%0d busy=%b, required 0 0 0 0",
                     oen_seen, valid_cnt - v0, err_cnt - e0, busy);
        end
    endtask

    task automatic test_read_attempt();
        int e0 = err_cnt;
        i2c_start();
        send_byte(8'h35, 1'b0, 1'b0);
        send_byte(8'h55, 1'b0, 1'b0);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL read_ignore_busy: got %b, required 1", busy);
        end
        i2c_stop();
        wait_clks(4);
        vectors++;
        if (wr_count !== 8'd1 || err_cnt != e0) begin
            miscompares++;
            $display("FAIL read_attempt: count=%0d err=%0d, required 1 0", wr_count, err_cnt - e0);
        end
    endtask

    task automatic test_abort_stop();
        int v0 = valid_cnt;
        int e0 = err_cnt;
        i2c_start();
        send_byte(8'h34, 1'b1, 1'b0);
        send_byte(8'h1E, 1'b1, 1'b0);
        i2c_stop();
        wait_clks(4);
        vectors++;
        if (err_cnt - e0 != 1 || valid_cnt != v0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_stop: err=%0d valid=%0d busy=%b, required 1 0 0",
                     err_cnt - e0, valid_cnt - v0, busy);
        end
        vectors++;
        if (wr_reg !== 7'h04 || wr_data !== 9'h015) begin
            miscompares++;
            $display("FAIL abort_hold: reg=%h data=%h, required 04 015", wr_reg, wr_data);
        end
    endtask

    task automatic test_extra_byte();
        int v0 = valid_cnt;
        int e0 = err_cnt;
        do_write(7'h0F, 9'h1FF);
        send_byte(8'hAA, 1'b0, 1'b0);
        i2c_stop();
        wait_clks(4);
        vectors++;
        if (valid_cnt - v0 != 1 || err_cnt != e0 || wr_count !== 8'd2 ||
            wr_reg !== 7'h0F || wr_data !== 9'h1FF) begin
            miscompares++;
            $display("FAIL extra_byte: valid=%0d err=%0d count=%0d reg=%h data=%h, required 1 0 2 0f 1ff",
                     valid_cnt - v0, err_cnt - e0, wr_count, wr_reg, wr_data);
        end
    endtask

    task automatic test_back_to_back();
        int v0 = valid_cnt;
        int e0 = err_cnt;
        i2c_start();
        send_byte(8'h34, 1'b1, 1'b0);
        send_byte(8'h0A, 1'b1, 1'b0);
        do_write(7'h05, 9'h0AA);   // its START is a repeated START mid-write
        i2c_stop();
        wait_clks(4);
        vectors++;
        if (err_cnt - e0 != 1 || valid_cnt - v0 != 1 || wr_count !== 8'd3) begin
            miscompares++;
            $display("FAIL rstart_abort: err=%0d valid=%0d count=%0d, required 1 1 3",
                     err_cnt - e0, valid_cnt - v0, wr_count);
        end
    endtask

    task automatic test_reset_mid_ack();
        int v0;
        int e0;
        i2c_start();
        send_byte(8'h34, 1'b1, 1'b1);
        i2c_stop();
        wait_clks(4);
        v0 = valid_cnt;
        e0 = err_cnt;
        do_write(7'h06, 9'h09F);
        i2c_stop();
        wait_clks(4);
        vectors++;
        if (valid_cnt - v0 != 1 || err_cnt != e0 || wr_count !== 8'd1) begin
            miscompares++;
            $display("FAIL post_reset_write: valid=%0d err=%0d count=%0d, required 1 0 1",
                     valid_cnt - v0, err_cnt - e0, wr_count);
        end
    endtask

    task automatic test_init_sequence();
        int v0;
        int e0;
        @(negedge clk) rst = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        wait_clks(2);
        v0 = valid_cnt;
        e0 = err_cnt;
        for (int k = 0; k < 11; k++) begin
            do_write(INIT_SEQ[k][15:9], INIT_SEQ[k][8:0]);
            if (k % 2 == 1) i2c_stop();   // even entries chain via repeated START
        end
        i2c_stop();
        wait_clks(4);
        vectors++;
        if (wr_count !== 8'd11 || valid_cnt - v0 != 11 || err_cnt != e0) begin
            miscompares++;
            $display("FAIL init_sequence: count=%0d valid=%0d err=%0d, required 11 11 0",
                     wr_count, valid_cnt - v0, err_cnt - e0);
        end
        vectors++;
        if (wr_reg !== 7'h09 || wr_data !== 9'h001) begin
            miscompares++;
            $display("FAIL init_last: reg=%h data=%h, required 09 001", wr_reg, wr_data);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_addr_mismatch();
        test_read_attempt();
        test_abort_stop();
        test_extra_byte();
        test_back_to_back();
        test_reset_mid_ack();
        test_init_sequence();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d writes outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_codec_target.md
Name: i2c_codec_target

Overview:
- Behavioural-synthesisable I2C target (responder) that models the WM8731 control port.
- It is the other end of the I2C initializer's write transactions: it receives the 3-byte write sequence, ACKs it, and reports each decoded register write.
- Used in the lab3 FPGA loopback bench and for on-chip self-check of the codec init sequence.
- Runs from a fast system clock that oversamples SCL/SDA; write-only, matching the WM8731 control interface.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit target address; write byte is {DEV_ADDR,1'b0} = 8'h34.
- SYNC_STAGES, 2, synchroniser depth on SCL and SDA; legal values are 2 or 3.

Ports:
- i_clk  input  1  system clock; must be at least 20x the SCL frequency.
- i_rst  input  1  asynchronous, active-high reset.
- i_scl  input  1  I2C clock from the initiator (open-drain, resolved level).
- i_sda  input  1  I2C data, resolved bus level.
- o_sda_oen  output  1  1 = pull SDA low (ACK); 0 = release.
- o_wr_valid  output  1  one-cycle pulse when a complete register write has been ACKed.
- o_wr_reg  output  7  register address of the last write; held until the next write.
- o_wr_data  output  9  register data of the last write; held until the next write.
- o_busy  output  1  high from START detection until STOP or abort.
- o_err  output  1  one-cycle pulse when a transaction is aborted before completion.
- o_wr_count  output  8  number of completed writes since reset; wraps 255 -> 0.

Behaviour:
- Reset:
  - All outputs are 0.
  - FSM enters S_IDLE and the shift register clears.
  - Reset may arrive mid-transaction; SDA is released immediately because o_sda_oen goes to 0 asynchronously.
- Synchronisation:
  - SCL and SDA each pass through SYNC_STAGES flops before use.
  - SCL rise/fall and SDA rise/fall are edge pulses derived from the synchronised values.
- Condition detection:
  - START = SDA fall while SCL is high.
  - STOP = SDA rise while SCL is high.
  - Both are detected in every state and take priority over bit sampling in the same cycle.
- Bit sampling:
  - Data bits are sampled on the synchronised SCL rising edge, MSB first.
  - The bit counter counts 0..7.
- FSM states:
  - S_IDLE: wait for START, then go to S_ADDR.
  - S_ADDR: shift 8 bits. On the 8th SCL fall:
    - if byte == {DEV_ADDR,0}, go to S_ACK_A;
    - otherwise (address mismatch or R/W=1), go to S_IGNORE with no ACK.
  - S_ACK_A: hold o_sda_oen = 1 from the 8th SCL fall to the 9th SCL fall, then go to S_B0.
  - S_B0: shift 8 bits; on the 8th fall, latch b0 and go to S_ACK_0 (ACK as above), then S_B1.
  - S_B1: shift 8 bits; on the 8th fall go to S_ACK_1.
    - At ACK start, update o_wr_reg = b0[7:1] and o_wr_data = {b0[0], b1}.
    - At ACK start, pulse o_wr_valid and increment o_wr_count.
  - S_ACK_1 -> S_DONE on the 9th SCL fall.
  - S_DONE: any further byte is not ACKed (NACK); wait for STOP or repeated START.
  - S_IGNORE: never drive SDA; wait for STOP or START.
- STOP handling:
  - STOP in S_IDLE, S_DONE or S_IGNORE: go to S_IDLE quietly.
  - STOP in any other state: go to S_IDLE and pulse o_err.
- Repeated START:
  - In any state it restarts at S_ADDR with the bit counter cleared.
  - It pulses o_err only if received before S_DONE, i.e. while mid-write.
- o_sda_oen is high only in the ACK states, and is registered (glitch-free).
- o_busy is 1 in every state except S_IDLE.
- Latency: o_wr_valid asserts SYNC_STAGES+1 i_clk cycles after the i_scl falling edge of the 24th data bit.

Test Plan:
- Write 8'h34, 8'h08, 8'h15, then STOP.
  - Expect ACK low in all 3 ninth-clock slots.
  - Expect one o_wr_valid pulse with o_wr_reg=7'h04, o_wr_data=9'h015, and o_wr_count=1.
  - o_err never pulses.
- Address 8'h36, then 2 bytes.
  - SDA is never pulled low; no o_wr_valid.
  - o_busy drops on STOP; o_err stays 0.
- Read attempt 8'h35.
  - No ACK; FSM reaches S_IGNORE; o_wr_count is unchanged.
- 8'h34, 8'h1E, then STOP before byte 2.
  - One o_err pulse and no o_wr_valid.
  - o_wr_reg/o_wr_data keep their previous values.
- 8'h34, 8'h1F, 8'hFF, then a 4th byte 8'hAA, then STOP.
  - Write of reg 7'h0F with data 9'h1FF is reported.
  - The 4th byte is NACKed; no o_err.
- Full 11-register init sequence.
  - o_wr_count = 11.
- Assert i_rst mid-way through byte 1 while o_sda_oen=1 during the ACK.
  - o_sda_oen = 0 in the same cycle; all outputs are 0.
  - A subsequent clean write is accepted normally.
